// File: rtl/neuron_pkg.sv
// Shared types and default sizing for the perceptron training controller.
// The state encoding is exported so the bench and debug logic can name states.
package neuron_pkg;

    localparam int N_SAMPLES = 4;
    localparam int ADDR_W    = 2;
    localparam int MAX_EPOCH = 15;
    localparam int EPOCH_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_EVAL,
        S_UPDATE,
        S_NEXT,
        S_CHECK,
        S_DONE
    } state_t;

endpackage

// File: rtl/mod_counter.sv
// Clear/increment counter with a terminal-count flag.
// Incrementing while at the terminal value wraps back to zero.
module mod_counter #(
    parameter int W    = 2,
    parameter int TERM = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (r_count == TERM_V) r_count <= '0;
            else                   r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TERM_V);

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Sequencer for the two-input perceptron training datapath: walks the samples,
// strobes load/update/clear, and stops on an error-free epoch or the epoch limit.
module perceptron_train_ctrl #(
    parameter int N_SAMPLES = neuron_pkg::N_SAMPLES,
    parameter int ADDR_W    = neuron_pkg::ADDR_W,
    parameter int MAX_EPOCH = neuron_pkg::MAX_EPOCH,
    parameter int EPOCH_W   = neuron_pkg::EPOCH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mismatch,
    output logic [ADDR_W-1:0]   addr,
    output logic                ld_x,
    output logic                ld_w,
    output logic                clr_w,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic                timeout,
    output logic [EPOCH_W-1:0]  epoch,
    output neuron_pkg::state_t  dbg_state
);

    import neuron_pkg::*;

    state_t r_state;
    state_t w_next;

    logic r_err_seen;
    logic r_converged;
    logic r_timeout;

    logic w_addr_clr, w_addr_inc, w_addr_tc;
    logic w_ep_clr, w_ep_inc, w_ep_tc;
    logic w_err_set, w_err_clr;
    logic w_flags_clr, w_set_conv, w_set_tmo;

    mod_counter #(.W(ADDR_W), .TERM(N_SAMPLES - 1)) u_addr_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_addr_clr),
        .i_inc   (w_addr_inc),
        .o_count (addr),
        .o_tc    (w_addr_tc)
    );

    mod_counter #(.W(EPOCH_W), .TERM(MAX_EPOCH - 1)) u_epoch_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_ep_clr),
        .i_inc   (w_ep_inc),
        .o_count (epoch),
        .o_tc    (w_ep_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_addr_clr  = 1'b0;
        w_addr_inc  = 1'b0;
        w_ep_clr    = 1'b0;
        w_ep_inc    = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_flags_clr = 1'b0;
        w_set_conv  = 1'b0;
        w_set_tmo   = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_next = S_INIT;
            S_INIT: begin
                w_addr_clr  = 1'b1;
                w_ep_clr    = 1'b1;
                w_err_clr   = 1'b1;
                w_flags_clr = 1'b1;
                w_next      = S_FETCH;
            end
            S_FETCH:  w_next = S_EVAL;
            S_EVAL:   w_next = mismatch ? S_UPDATE : S_NEXT;
            S_UPDATE: begin
                w_err_set = 1'b1;
                w_next    = S_NEXT;
            end
            // The address counter wraps to 0 on its own when leaving the last sample.
            S_NEXT: begin
                w_addr_inc = 1'b1;
                w_next     = w_addr_tc ? S_CHECK : S_FETCH;
            end
            S_CHECK: begin
                if (!r_err_seen) begin
                    w_set_conv = 1'b1;
                    w_next     = S_DONE;
                end else if (w_ep_tc) begin
                    w_set_tmo = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_ep_inc  = 1'b1;
                    w_err_clr = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_DONE:   if (!start) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_seen  <= 1'b0;
            r_converged <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_err_clr)      r_err_seen <= 1'b0;
            else if (w_err_set) r_err_seen <= 1'b1;

            if (w_flags_clr) begin
                r_converged <= 1'b0;
                r_timeout   <= 1'b0;
            end else begin
                if (w_set_conv) r_converged <= 1'b1;
                if (w_set_tmo)  r_timeout   <= 1'b1;
            end
        end
    end

    assign ld_x      = (r_state == S_FETCH);
    assign ld_w      = (r_state == S_UPDATE);
    assign clr_w     = (r_state == S_INIT);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign converged = r_converged;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl: cycle-accurate training runs with
// hand-computed strobe counts, completion cycles and result flags.
module tb_perceptron_train_ctrl;

    import neuron_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic              mismatch;
    logic [1:0]        addr;
    logic              ld_x, ld_w, clr_w, busy, done, converged, timeout;
    logic [3:0]        epoch;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;

    // Statistics collected by run(); cycle 0 is the cycle in which start is first high.
    int s_init_cyc, s_clr_cyc, s_first_ldx_cyc, s_first_check_cyc, s_done_cyc;
    int s_ldx_n, s_ldw_n, s_check_n, s_last_ldw_addr;
    int s_first_ldx_addr, s_first_ldx_epoch;
    logic s_conv_c2, s_tmo_c2;
    bit s_done_seen, s_aborted;

    perceptron_train_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mismatch  (mismatch),
        .addr      (addr),
        .ld_x      (ld_x),
        .ld_w      (ld_w),
        .clr_w     (clr_w),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .timeout   (timeout),
        .epoch     (epoch),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: 0 = always correct, 1 = wrong only at addr 2 in epoch 0, 2 = always wrong.
    function automatic logic model_mismatch(input int mode, input logic [1:0] a, input logic [3:0] e);
        case (mode)
            1:       return (a == 2'd2) && (e == 4'd0);
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // start_mode: 0 = single pulse, 1 = held high, 2 = toggled every cycle while busy.
    // abort_ep >= 0 stops the run on the first UPDATE cycle of that epoch.
    task automatic run(input int mode, input int start_mode, input int abort_ep);
        int cyc;
        s_init_cyc = -1; s_clr_cyc = -1; s_first_ldx_cyc = -1; s_first_check_cyc = -1;
        s_done_cyc = -1; s_ldx_n = 0; s_ldw_n = 0; s_check_n = 0; s_last_ldw_addr = -1;
        s_first_ldx_addr = -1; s_first_ldx_epoch = -1; s_conv_c2 = 1'bx; s_tmo_c2 = 1'bx;
        s_done_seen = 0; s_aborted = 0;
        @(negedge clk);
        start    = 1'b1;
        mismatch = model_mismatch(mode, addr, epoch);
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (dbg_state == S_INIT && s_init_cyc < 0) s_init_cyc = cyc;
            if (clr_w && s_clr_cyc < 0) s_clr_cyc = cyc;
            if (ld_x) begin
                if (s_first_ldx_cyc < 0) begin
                    s_first_ldx_cyc   = cyc;
                    s_first_ldx_addr  = int'(addr);
                    s_first_ldx_epoch = int'(epoch);
                end
                s_ldx_n++;
            end
            if (ld_w) begin
                s_ldw_n++;
                s_last_ldw_addr = int'(addr);
            end
            if (dbg_state == S_CHECK) begin
                if (s_first_check_cyc < 0) s_first_check_cyc = cyc;
                s_check_n++;
            end
            if (cyc == 2) begin
                s_conv_c2 = converged;
                s_tmo_c2  = timeout;
            end
            mismatch = model_mismatch(mode, addr, epoch);
            case (start_mode)
                1:       start = 1'b1;
                2:       start = cyc[0];
                default: start = 1'b0;
            endcase
            if (abort_ep >= 0 && dbg_state == S_UPDATE && int'(epoch) == abort_ep) begin
                s_aborted = 1;
                break;
            end
            if (done) begin
                s_done_seen = 1;
                s_done_cyc  = cyc;
                if (start_mode != 1) start = 1'b0;
                break;
            end
        end
        checks++;
        if (!s_done_seen && !s_aborted) begin
            errors++;
            $display("FAIL run_bound: no completion within 400 cycles (mode %0d)", mode);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mismatch = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
        end
        checks++;
        if ({ld_x, ld_w, clr_w, busy, done, converged, timeout} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000000",
                               {ld_x, ld_w, clr_w, busy, done, converged, timeout});
        end
        checks++;
        if (addr !== 2'd0 || epoch !== 4'd0) begin
            errors++; $display("FAIL reset_counters: got addr %0d epoch %0d want 0 0", addr, epoch);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_epoch();
        run(0, 0, -1);
        checks++;
        if (s_init_cyc !== 1 || s_clr_cyc !== 1) begin
            errors++; $display("FAIL clean_init: got init %0d clr %0d want 1 1", s_init_cyc, s_clr_cyc);
        end
        checks++;
        if (s_first_ldx_cyc !== 2 || s_ldx_n !== 4) begin
            errors++; $display("FAIL clean_ldx: got first %0d count %0d want 2 4", s_first_ldx_cyc, s_ldx_n);
        end
        checks++;
        if (s_first_check_cyc !== 14 || s_done_cyc !== 15) begin
            errors++; $display("FAIL clean_timing: got check %0d done %0d want 14 15",
                               s_first_check_cyc, s_done_cyc);
        end
        checks++;
        if (converged !== 1'b1 || timeout !== 1'b0 || epoch !== 4'd0 || s_ldw_n !== 0) begin
            errors++; $display("FAIL clean_result: got conv %b tmo %b epoch %0d ldw %0d want 1 0 0 0",
                               converged, timeout, epoch, s_ldw_n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL clean_busy_in_done: got %b want 0", busy);
        end
    endtask

    task automatic test_single_error();
        run(1, 0, -1);
        checks++;
        if (s_ldw_n !== 1 || s_last_ldw_addr !== 2) begin
            errors++; $display("FAIL single_ldw: got count %0d addr %0d want 1 2", s_ldw_n, s_last_ldw_addr);
        end
        checks++;
        if (s_done_cyc !== 29 || s_check_n !== 2) begin
            errors++; $display("FAIL single_timing: got done %0d checks %0d want 29 2", s_done_cyc, s_check_n);
        end
        checks++;
        if (converged !== 1'b1 || timeout !== 1'b0 || epoch !== 4'd1) begin
            errors++; $display("FAIL single_result: got conv %b tmo %b epoch %0d want 1 0 1",
                               converged, timeout, epoch);
        end
    endtask

    task automatic test_timeout();
        run(2, 0, -1);
        checks++;
        if (timeout !== 1'b1 || converged !== 1'b0 || epoch !== 4'd14) begin
            errors++; $display("FAIL tmo_result: got tmo %b conv %b epoch %0d want 1 0 14",
                               timeout, converged, epoch);
        end
        checks++;
        if (s_ldw_n !== 60 || s_check_n !== 15 || s_ldx_n !== 60) begin
            errors++; $display("FAIL tmo_counts: got ldw %0d check %0d ldx %0d want 60 15 60",
                               s_ldw_n, s_check_n, s_ldx_n);
        end
        checks++;
        if (s_done_cyc !== 257) begin
            errors++; $display("FAIL tmo_timing: got done %0d want 257", s_done_cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        run(2, 0, 3);
        checks++;
        if (!s_aborted || dbg_state !== S_UPDATE || epoch !== 4'd3) begin
            errors++; $display("FAIL midrst_reach: got aborted %0d state %0d epoch %0d want 1 %0d 3",
                               s_aborted, dbg_state, epoch, S_UPDATE);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dbg_state !== S_IDLE || addr !== 2'd0 || epoch !== 4'd0) begin
            errors++; $display("FAIL midrst_state: got state %0d addr %0d epoch %0d want %0d 0 0",
                               dbg_state, addr, epoch, S_IDLE);
        end
        checks++;
        if ({ld_x, ld_w, clr_w, busy, done, converged, timeout} !== 7'b0) begin
            errors++; $display("FAIL midrst_flags: got %b want 0000000",
                               {ld_x, ld_w, clr_w, busy, done, converged, timeout});
        end
        mismatch = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run(0, 0, -1);
        checks++;
        if (s_clr_cyc !== 1 || s_first_ldx_addr !== 0 || s_first_ldx_epoch !== 0) begin
            errors++; $display("FAIL midrst_restart: got clr %0d addr %0d epoch %0d want 1 0 0",
                               s_clr_cyc, s_first_ldx_addr, s_first_ldx_epoch);
        end
        checks++;
        if (s_done_cyc !== 15 || converged !== 1'b1) begin
            errors++; $display("FAIL midrst_rerun: got done %0d conv %b want 15 1", s_done_cyc, converged);
        end
    endtask

    task automatic test_start_held();
        run(0, 1, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dbg_state !== S_DONE || done !== 1'b1) begin
                errors++; $display("FAIL held_stay: cycle %0d got state %0d done %b want %0d 1",
                                   i, dbg_state, done, S_DONE);
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || done !== 1'b0 || converged !== 1'b1) begin
            errors++; $display("FAIL held_release: got state %0d done %b conv %b want %0d 0 1",
                               dbg_state, done, converged, S_IDLE);
        end
        run(2, 0, -1);
        checks++;
        if (s_conv_c2 !== 1'b0 || timeout !== 1'b1) begin
            errors++; $display("FAIL held_clear_conv: got conv@2 %b tmo %b want 0 1", s_conv_c2, timeout);
        end
        run(0, 0, -1);
        checks++;
        if (s_tmo_c2 !== 1'b0 || timeout !== 1'b0 || converged !== 1'b1) begin
            errors++; $display("FAIL held_clear_tmo: got tmo@2 %b tmo %b conv %b want 0 0 1",
                               s_tmo_c2, timeout, converged);
        end
    endtask

    task automatic test_start_toggle();
        run(1, 2, -1);
        checks++;
        if (s_done_cyc !== 29 || s_ldw_n !== 1 || s_ldx_n !== 8 || s_check_n !== 2) begin
            errors++; $display("FAIL toggle_trace: got done %0d ldw %0d ldx %0d chk %0d want 29 1 8 2",
                               s_done_cyc, s_ldw_n, s_ldx_n, s_check_n);
        end
        checks++;
        if (converged !== 1'b1 || epoch !== 4'd1 || s_last_ldw_addr !== 2) begin
            errors++; $display("FAIL toggle_result: got conv %b epoch %0d ldw_addr %0d want 1 1 2",
                               converged, epoch, s_last_ldw_addr);
        end
    endtask

    initial begin
        test_reset();
        test_clean_epoch();
        test_single_error();
        test_timeout();
        test_reset_mid_run();
        test_start_held();
        test_start_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/perceptron_train_ctrl.md
# perceptron_train_ctrl

Sequencing controller for the two-input perceptron (neuron) training datapath. It walks the sample memory one sample at a time and pulses the datapath's load, clear and weight-update strobes. It tracks whether any sample produced an error during the current epoch and stops on convergence (an error-free epoch) or when the epoch limit is reached. It sits between the top-level start/done handshake and the neuron datapath (x1/x2/T registers, W1/W2/bias registers, output comparator).

## Interface
Parameters:
- N_SAMPLES, 4, number of training samples per epoch (≥2)
- ADDR_W, 2, sample address width; 2^ADDR_W ≥ N_SAMPLES
- MAX_EPOCH, 15, epoch limit (≥1)
- EPOCH_W, 4, epoch counter width; 2^EPOCH_W ≥ MAX_EPOCH

Ports (clock and reset first):
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level request to begin training
- mismatch  in  1  datapath output y ≠ target T; valid only in EVAL
- addr  out  ADDR_W  sample memory address (combinational memory)
- ld_x  out  1  load x1, x2, T from memory into datapath registers
- ld_w  out  1  apply weight/bias update (W += T·x)
- clr_w  out  1  zero weights and bias
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- converged  out  1  registered; last run ended on an error-free epoch
- timeout  out  1  registered; last run hit MAX_EPOCH without converging
- epoch  out  EPOCH_W  index of the current epoch (0-based); holds its final value in DONE

## Operation
States: IDLE, INIT, FETCH, EVAL, UPDATE, NEXT, CHECK, DONE.
- IDLE: all strobes low. start=1 → INIT.
- INIT: clr_w=1. Sets addr←0, epoch←0 and err_seen←0, and clears converged and timeout. → FETCH.
- FETCH: ld_x=1. → EVAL.
- EVAL: samples mismatch. mismatch=1 → UPDATE; otherwise → NEXT.
- UPDATE: ld_w=1, err_seen←1. → NEXT.
- NEXT: if addr=N_SAMPLES−1, then addr←0 and → CHECK. Otherwise addr←addr+1 and → FETCH.
- CHECK: err_seen=0 → DONE with converged←1. Otherwise, if epoch=MAX_EPOCH−1 → DONE with timeout←1. Otherwise epoch←epoch+1, err_seen←0, → FETCH.
- DONE: done=1. start=0 → IDLE. While start stays high, the controller remains in DONE and does not restart.
- Strobes are Moore outputs decoded from the present state. Each strobe is high for exactly one cycle per visit.
- err_seen is an internal flag register, not a port.
- start is ignored in every state except IDLE and DONE.
- converged and timeout are mutually exclusive. Both hold from DONE until the next INIT.
- addr never exceeds N_SAMPLES−1. epoch never exceeds MAX_EPOCH−1.

## Timing
- Reset (async, any state): state=IDLE; addr=0, epoch=0, err_seen=0. Every output is 0, including converged and timeout. Datapath weights are not touched by the controller.
- start is sampled at edge k → INIT in cycle k+1 → first ld_x in cycle k+2.
- Per sample: 3 cycles (FETCH, EVAL, NEXT), plus 1 cycle if UPDATE is taken.
- Per epoch: 3·N_SAMPLES + (number of updates) + 1 (CHECK).
- Reset asserted mid-run aborts immediately. A new start is required afterwards, and INIT re-clears the weights.
- A mismatch in the last sample of the epoch still sets err_seen before CHECK, because UPDATE precedes NEXT.

## Structure
- Shared package `neuron_pkg`: the state enum type and the default constants N_SAMPLES, MAX_EPOCH, ADDR_W, EPOCH_W.
- One sub-module is natural: `mod_counter`, a clear/increment/terminal-count counter. It is instantiated twice, once for addr (terminal N_SAMPLES−1) and once for epoch (terminal MAX_EPOCH−1).
- The FSM, err_seen and the result flags stay in the top module.

## Test plan
- mismatch tied 0, start pulsed at cycle 0 → INIT at cycle 1, four ld_x pulses, CHECK at cycle 14, done=1 at cycle 15; converged=1, epoch=0, zero ld_w pulses.
- mismatch=1 only while addr=2 in epoch 0 → exactly one ld_w, at addr=2; epoch 1 is clean → converged=1, epoch=1, done at cycle 29.
- mismatch tied 1 → timeout=1, converged=0, epoch=14, 60 ld_w pulses, exactly 15 CHECK visits.
- rst asserted during UPDATE of epoch 3 → same cycle: IDLE, all outputs 0. A new start produces clr_w and restarts at epoch 0, addr 0.
- start held high through DONE → stays in DONE with done=1. Drop start → IDLE. Re-raise start → INIT clears converged and timeout.
- start toggled while busy → no effect on state or counters; compare against the reference trace of the same run.
